// File: rtl/shift_frame_tx_if.sv
// ---------------------------------------------------------------------------
// shift_frame_tx_if
//
// Purpose:
//   Bundles the word handshake and the framed serial line of shift_frame_tx
//   into one interface so the transmitter and its producer share a single
//   port.
//
// Signals:
//   data_in     8-bit parallel word from the upstream shift register
//   data_valid  data_in holds a word to send
//   data_ready  transmitter can accept a word this cycle
//   serial_out  framed serial line, idle high
//   busy        a frame is in progress
//   frame_done  one-cycle pulse in the first idle clock after a frame
//
// Modports:
//   master  word producer (drives data_in / data_valid)
//   slave   the transmitter (drives everything else)
// ---------------------------------------------------------------------------
interface shift_frame_tx_if;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       serial_out;
    logic       busy;
    logic       frame_done;

    // Producer side: offers words, watches the transmitter status
    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  serial_out,
        input  busy,
        input  frame_done
    );

    // Transmitter side: consumes words, produces the line and status
    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output serial_out,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/shift_frame_tx.sv
// ---------------------------------------------------------------------------
// shift_frame_tx
//
// Purpose:
//   Takes an 8-bit word through a valid/ready handshake and sends it as a
//   framed serial stream: one start bit (0), eight data bits, an optional
//   even-parity bit, and one stop bit (1). Every bit is held for BIT_CYCLES
//   clocks. The line idles high.
//
// Parameters:
//   BIT_CYCLES  clocks per serial bit, 1..255
//   LSB_FIRST   1 = data bit 0 sent first, 0 = data bit 7 sent first
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    shift_frame_tx_if.slave (data_in, data_valid, data_ready,
//          serial_out, busy, frame_done)
//
// Configuration macro:
//   PARITY_EN  when defined, a PARITY bit (XOR of the eight captured data
//              bits, i.e. even parity) is inserted between DATA and STOP,
//              making a frame 11*BIT_CYCLES clocks instead of 10*BIT_CYCLES.
// ---------------------------------------------------------------------------
module shift_frame_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             reset,
    shift_frame_tx_if.slave  bus
);

    // Last value of the per-bit cycle counter before a bit boundary
    localparam logic [7:0] LAST_CYCLE = 8'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] cycleCnt_q,  cycleCnt_d;
    logic [2:0] bitIdx_q,    bitIdx_d;
    logic [7:0] shiftReg_q,  shiftReg_d;
    logic       serialOut_q, serialOut_d;
    logic       busy_q,      busy_d;
    logic       dataReady_q, dataReady_d;
    logic       frameDone_q, frameDone_d;
`ifdef PARITY_EN
    logic       parity_q,    parity_d;
`endif

    logic bitEnd;
    logic nextDataBit;

    // A bit period ends when the cycle counter reaches its last value; with
    // BIT_CYCLES=1 this is true on every clock, so no bubbles are added.
    assign bitEnd = (cycleCnt_q == LAST_CYCLE);

    // The bit that goes on the line next is always at one end of the holding
    // register, because the register shifts toward that end after each bit.
    assign nextDataBit = (LSB_FIRST != 0) ? shiftReg_d[0] : shiftReg_d[7];

    // State register plus registered outputs. The outputs are computed from
    // the next state so they change on the same edge as the state and carry
    // no combinational path from the handshake inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cycleCnt_q  <= '0;
            bitIdx_q    <= '0;
            shiftReg_q  <= '0;
            serialOut_q <= 1'b1;
            busy_q      <= 1'b0;
            dataReady_q <= 1'b0;
            frameDone_q <= 1'b0;
`ifdef PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cycleCnt_q  <= cycleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shiftReg_q  <= shiftReg_d;
            serialOut_q <= serialOut_d;
            busy_q      <= busy_d;
            dataReady_q <= dataReady_d;
            frameDone_q <= frameDone_d;
`ifdef PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state logic. The word is latched into the holding register at the
    // handshake, so later changes on data_in cannot disturb a frame. Words
    // offered while data_ready is low are simply not looked at. The cycle
    // counter restarts at every bit boundary and never passes LAST_CYCLE.
    always_comb begin
        state_d     = state_q;
        cycleCnt_d  = cycleCnt_q;
        bitIdx_d    = bitIdx_q;
        shiftReg_d  = shiftReg_q;
        frameDone_d = 1'b0;
`ifdef PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.data_valid && dataReady_q) begin
                    shiftReg_d = bus.data_in;
`ifdef PARITY_EN
                    parity_d   = ^bus.data_in;
`endif
                    cycleCnt_d = '0;
                    bitIdx_d   = '0;
                    state_d    = START;
                end
            end

            START: begin
                if (bitEnd) begin
                    cycleCnt_d = '0;
                    bitIdx_d   = '0;
                    state_d    = DATA;
                end else begin
                    cycleCnt_d = cycleCnt_q + 8'd1;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    cycleCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        if (LSB_FIRST != 0) begin
                            shiftReg_d = {1'b0, shiftReg_q[7:1]};
                        end else begin
                            shiftReg_d = {shiftReg_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cycleCnt_d = cycleCnt_q + 8'd1;
                end
            end

`ifdef PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    cycleCnt_d = '0;
                    state_d    = STOP;
                end else begin
                    cycleCnt_d = cycleCnt_q + 8'd1;
                end
            end
`endif

            STOP: begin
                if (bitEnd) begin
                    cycleCnt_d  = '0;
                    frameDone_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cycleCnt_d = cycleCnt_q + 8'd1;
                end
            end

            default: begin
                cycleCnt_d = '0;
                bitIdx_d   = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Output decode from the next state. data_ready rises in the first IDLE
    // clock after STOP, which lets a held data_valid be accepted in the
    // frame_done cycle and leaves exactly one idle-high clock between frames.
    always_comb begin
        busy_d      = (state_d != IDLE);
        dataReady_d = (state_d == IDLE);
        serialOut_d = 1'b1;

        case (state_d)
            START:   serialOut_d = 1'b0;
            DATA:    serialOut_d = nextDataBit;
`ifdef PARITY_EN
            PARITY:  serialOut_d = parity_d;
`endif
            default: serialOut_d = 1'b1;
        endcase
    end

    assign bus.serial_out = serialOut_q;
    assign bus.busy       = busy_q;
    assign bus.data_ready = dataReady_q;
    assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_shift_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_shift_frame_tx
//
// Purpose:
//   Directed bench for shift_frame_tx. Two instances share clock and reset:
//   dutA (BIT_CYCLES=4, LSB first) and dutB (BIT_CYCLES=1, MSB first).
//   A table of words with hand-written expected bit orders and parity is
//   sent through both, followed by hand-written sequences for reset,
//   back-to-back frames and a mid-frame reset.
// ---------------------------------------------------------------------------
module tb_shift_frame_tx;

`ifdef PARITY_EN
    localparam int NSLOTS = 11;
`else
    localparam int NSLOTS = 10;
`endif

    typedef struct {
        logic [7:0] word;
        logic [7:0] lsbOrder;   // line order for LSB first, leftmost bit sent first
        logic [7:0] msbOrder;   // line order for MSB first, leftmost bit sent first
        logic       parity;
    } vec_t;

    logic clk;
    logic reset;

    int checkCount;
    int passCount;

    vec_t vecs[5];

    shift_frame_tx_if ifA();
    shift_frame_tx_if ifB();

    shift_frame_tx #(.BIT_CYCLES(4), .LSB_FIRST(1)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifA)
    );

    shift_frame_tx #(.BIT_CYCLES(1), .LSB_FIRST(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifB)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {serial_out, busy, data_ready, frame_done} of the selected instance
    function automatic logic [3:0] status(int sel);
        if (sel == 0) return {ifA.serial_out, ifA.busy, ifA.data_ready, ifA.frame_done};
        return {ifB.serial_out, ifB.busy, ifB.data_ready, ifB.frame_done};
    endfunction

    task automatic driveInputs(int sel, logic valid, logic [7:0] data);
        if (sel == 0) begin
            ifA.data_valid = valid;
            ifA.data_in    = data;
        end else begin
            ifB.data_valid = valid;
            ifB.data_in    = data;
        end
    endtask

    task automatic checkValue(string name, logic [7:0] actual, logic [7:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Offer a word at a negedge, wait for data_ready, let the handshake edge
    // pass, and return at the negedge of the first START clock.
    task automatic applyStimulus(int sel, logic [7:0] word, logic holdValid);
        logic [3:0] st;
        bit found;
        found = 0;
        driveInputs(sel, 1'b1, word);
        for (int i = 0; i < 300; i++) begin
            st = status(sel);
            if (st[1]) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checkCount++;
            $display("[TB] FAIL handshake dut%0d: data_ready got 0, expected 1 within 300 cycles", sel);
            driveInputs(sel, 1'b0, word);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!holdValid) driveInputs(sel, 1'b0, word);
    endtask

    // Check every clock of a frame, one comparison per bit slot, then the
    // frame_done cycle. Up to two data_in changes can be injected mid-frame.
    task automatic checkOutput(int sel, string tag, logic [7:0] order, logic par,
                               int changeAt1, logic [7:0] changeVal1,
                               int changeAt2, logic [7:0] changeVal2);
        int bc;
        int sampleNo;
        logic expLine;
        logic [3:0] expSt;
        logic [3:0] actSt;
        logic [3:0] st;
        bc = (sel == 0) ? 4 : 1;
        sampleNo = 0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (s == 0) expLine = 1'b0;
            else if (s <= 8) expLine = order[8 - s];
            else if (s == NSLOTS - 1) expLine = 1'b1;
            else expLine = par;
            expSt = {expLine, 1'b1, 1'b0, 1'b0};
            for (int c = 0; c < bc; c++) begin
                if (sampleNo > 0) @(negedge clk);
                sampleNo++;
                if (sampleNo == changeAt1) driveInputs(sel, (sel == 0) ? ifA.data_valid : ifB.data_valid, changeVal1);
                if (sampleNo == changeAt2) driveInputs(sel, (sel == 0) ? ifA.data_valid : ifB.data_valid, changeVal2);
                st = status(sel);
                if (c == 0) actSt = st;
                else if (actSt == expSt && st != expSt) actSt = st;
            end
            checkValue($sformatf("%s dut%0d slot%0d", tag, sel, s), {4'h0, actSt}, {4'h0, expSt});
        end
        @(negedge clk);
        checkValue($sformatf("%s dut%0d done-cycle", tag, sel), {4'h0, status(sel)}, 8'h0B);
    endtask

    initial begin
        logic [3:0] st;
        logic [7:0] badSt;
        checkCount = 0;
        passCount  = 0;

        vecs[0] = '{word: 8'hE5, lsbOrder: 8'b10100111, msbOrder: 8'b11100101, parity: 1'b1};
        vecs[1] = '{word: 8'h03, lsbOrder: 8'b11000000, msbOrder: 8'b00000011, parity: 1'b0};
        vecs[2] = '{word: 8'hA5, lsbOrder: 8'b10100101, msbOrder: 8'b10100101, parity: 1'b0};
        vecs[3] = '{word: 8'h5A, lsbOrder: 8'b01011010, msbOrder: 8'b01011010, parity: 1'b0};
        vecs[4] = '{word: 8'h80, lsbOrder: 8'b00000001, msbOrder: 8'b10000000, parity: 1'b1};

        // Reset held for two clocks; data_valid already high must be ignored
        reset = 1'b0;
        driveInputs(0, 1'b1, 8'h55);
        driveInputs(1, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkValue($sformatf("reset dutA clk%0d", i), {4'h0, status(0)}, 8'h08);
            checkValue($sformatf("reset dutB clk%0d", i), {4'h0, status(1)}, 8'h08);
        end
        driveInputs(0, 1'b0, 8'h55);
        reset = 1'b1;
        #1;
        checkValue("release dutA pre-edge", {4'h0, status(0)}, 8'h08);
        @(negedge clk);
        checkValue("release dutA first edge", {4'h0, status(0)}, 8'h0A);
        checkValue("release dutB first edge", {4'h0, status(1)}, 8'h0A);

        // Table-driven frames through both instances
        for (int v = 0; v < 5; v++) begin
            for (int sel = 0; sel < 2; sel++) begin
                applyStimulus(sel, vecs[v].word, 1'b0);
                checkOutput(sel, $sformatf("vec%0d", v),
                            (sel == 0) ? vecs[v].lsbOrder : vecs[v].msbOrder,
                            vecs[v].parity, 0, 8'h00, 0, 8'h00);
                @(negedge clk);
                checkValue($sformatf("vec%0d dut%0d after-done", v, sel), {4'h0, status(sel)}, 8'h0A);
            end
        end

        // Back-to-back: data_valid stays high; data_in goes to FF mid-frame,
        // then to 5A so the second word is taken in the frame_done cycle.
        applyStimulus(0, 8'hA5, 1'b1);
        checkOutput(0, "b2b first", vecs[2].lsbOrder, vecs[2].parity, 3, 8'hFF, 30, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        driveInputs(0, 1'b0, 8'h5A);
        checkOutput(0, "b2b second", vecs[3].lsbOrder, vecs[3].parity, 0, 8'h00, 0, 8'h00);
        @(negedge clk);
        checkValue("b2b after-done", {4'h0, status(0)}, 8'h0A);

        // Reset at clock 15 of a frame of zeros (line low at that point)
        applyStimulus(0, 8'h00, 1'b0);
        for (int i = 1; i < 15; i++) @(negedge clk);
        checkValue("abort clk15 line", {4'h0, status(0)}, 8'h04);
        reset = 1'b0;
        #1;
        checkValue("abort immediate", {4'h0, status(0)}, 8'h08);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        badSt = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            st = status(0);
            if (st[3] !== 1'b1 || st[2] !== 1'b0 || st[0] !== 1'b0) badSt = {4'h0, st};
        end
        checkValue("abort no resume/no done", badSt, 8'h00);
        applyStimulus(0, 8'hE5, 1'b0);
        checkOutput(0, "post-abort", vecs[0].lsbOrder, vecs[0].parity, 0, 8'h00, 0, 8'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
